// File: rtl/audio_tone_seq.sv
// audio_tone_seq
//   Plays a fixed 16-step melody as a 1-bit square wave while the
//   (synchronized) audio_en control bit is high.
//
//   Build option: define AUDIO_ENVELOPE_EN to add a per-step decaying
//   volume envelope applied as 4-bit PWM on top of the square wave.
//
// Parameters
//   STEP_CYCLES : clk cycles per melody step (>= 32)
//   TONE_SHIFT  : right-shift applied to every ROM half-period
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   audio_en  in   enable, asynchronous to clk (2-flop synchronized)
//   audio_out out  registered square-wave audio
//   playing   out  high while in PLAY
//   step_idx  out  current melody step (0..15)
module audio_tone_seq #(
  parameter int unsigned STEP_CYCLES = 3_146_875,
  parameter int unsigned TONE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       audio_en,
  output logic       audio_out,
  output logic       playing,
  output logic [3:0] step_idx
);

  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  // Note half-periods in clk cycles; 0 marks a rest.
  localparam logic [15:0] HP_C4   = 16'd48112;
  localparam logic [15:0] HP_D4   = 16'd42864;
  localparam logic [15:0] HP_E4   = 16'd38187;
  localparam logic [15:0] HP_G4   = 16'd32111;
  localparam logic [15:0] HP_A4   = 16'd28608;
  localparam logic [15:0] HP_C5   = 16'd24056;
  localparam logic [15:0] HP_REST = 16'd0;

  function automatic logic [15:0] melody_half(input logic [3:0] idx);
    logic [15:0] hp;
    case (idx)
      4'd0:    hp = HP_C4;
      4'd1:    hp = HP_D4;
      4'd2:    hp = HP_E4;
      4'd3:    hp = HP_C4;
      4'd4:    hp = HP_E4;
      4'd5:    hp = HP_G4;
      4'd6:    hp = HP_A4;
      4'd7:    hp = HP_REST;
      4'd8:    hp = HP_A4;
      4'd9:    hp = HP_G4;
      4'd10:   hp = HP_E4;
      4'd11:   hp = HP_D4;
      4'd12:   hp = HP_C5;
      4'd13:   hp = HP_A4;
      4'd14:   hp = HP_G4;
      default: hp = HP_REST;
    endcase
    return hp;
  endfunction

  logic              sync1;
  logic              en_s;
  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [STEP_W-1:0] step_cnt;
  logic [15:0]       tone_cnt;
  logic              phase;
  logic [15:0]       half;
  logic              step_end;
  logic              active;
  logic              tone_bit;

  assign half     = melody_half(step_idx) >> TONE_SHIFT;
  assign step_end = (step_cnt == STEP_LAST);
  // True only when this cycle both starts and ends in PLAY; entry, exit
  // and idle cycles all clear the datapath instead.
  assign active   = (state == ST_PLAY) && (state_next == ST_PLAY);
  assign playing  = (state == ST_PLAY);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en_s)  state_next = ST_PLAY;
      default: if (!en_s) state_next = ST_IDLE;
    endcase
  end

`ifdef AUDIO_ENVELOPE_EN
  localparam int unsigned ENV_DIV = STEP_CYCLES >> 4;
  localparam logic [STEP_W-1:0] ENV_LAST = STEP_W'(ENV_DIV - 1);

  logic [3:0]        vol;
  logic [3:0]        pwm_cnt;
  logic [STEP_W-1:0] env_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vol     <= '1;
      pwm_cnt <= '0;
      env_cnt <= '0;
    end else if (!active) begin
      vol     <= '1;
      pwm_cnt <= '0;
      env_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (step_end) begin
        vol     <= '1;
        env_cnt <= '0;
      end else if (env_cnt == ENV_LAST) begin
        env_cnt <= '0;
        if (vol != 4'd0) vol <= vol - 4'd1;
      end else begin
        env_cnt <= env_cnt + STEP_W'(1);
      end
    end
  end

  assign tone_bit = phase & (pwm_cnt < vol);
`else
  assign tone_bit = phase;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      en_s  <= 1'b0;
    end else begin
      sync1 <= audio_en;
      en_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      step_cnt  <= '0;
      step_idx  <= '0;
      tone_cnt  <= '0;
      phase     <= 1'b0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_next;
      audio_out <= active ? tone_bit : 1'b0;
      if (!active) begin
        step_cnt <= '0;
        step_idx <= '0;
        tone_cnt <= '0;
        phase    <= 1'b0;
      end else if (step_end) begin
        // Step boundary wins over any tone toggle due this cycle.
        step_cnt <= '0;
        step_idx <= step_idx + 4'd1;
        tone_cnt <= '0;
        phase    <= 1'b0;
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
        if (half == 16'd0) begin
          tone_cnt <= '0;
          phase    <= 1'b0;
        end else if (tone_cnt == half - 16'd1) begin
          tone_cnt <= '0;
          phase    <= ~phase;
        end else begin
          tone_cnt <= tone_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_seq.sv
// Testbench for audio_tone_seq: random enable patterns, a time-based
// melody model, and a queue scoreboard checked every falling edge.
module tb_audio_tone_seq;

  localparam int SC = 2000;
  localparam int TS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       audio_en = 1'b0;
  logic       audio_out;
  logic       playing;
  logic [3:0] step_idx;

  always #5 clk = ~clk;

  audio_tone_seq #(.STEP_CYCLES(SC), .TONE_SHIFT(TS)) dut (
    .clk(clk),
    .rst(rst),
    .audio_en(audio_en),
    .audio_out(audio_out),
    .playing(playing),
    .step_idx(step_idx)
  );

  typedef struct packed {
    logic       playing;
    logic [3:0] step;
    logic       audio;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  // model state
  bit m_d1 = 0, m_d2 = 0, m_play = 0;
  int m_t = 0;
  bit last_exp_audio = 0;

  function automatic int half_of(input int s);
    int rom[16] = '{48112, 42864, 38187, 48112, 38187, 32111, 28608, 0,
                    28608, 32111, 38187, 42864, 24056, 28608, 32111, 0};
    return rom[s] >> TS;
  endfunction

  // Square-wave level t cycles after PLAY entry.
  function automatic bit phase_at(input int t);
    int w = t % SC;
    int h = half_of((t / SC) % 16);
    if (h == 0) return 1'b0;
    return ((w / h) % 2) == 1;
  endfunction

  function automatic bit gate_at(input int t);
`ifdef AUDIO_ENVELOPE_EN
    int w = t % SC;
    int d = SC >> 4;
    int v = 15 - ((w / d) > 15 ? 15 : (w / d));
    return (t % 16) < v;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle: inputs change mid-low-phase, model advances at the edge.
  task automatic tick(input bit en, input bit r);
    exp_t e;
    bit p;
    @(negedge clk);
    #2;
    audio_en = en;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      check("async_reset_playing", playing, 0);
      check("async_reset_step", step_idx, 0);
      check("async_reset_audio", audio_out, 0);
    end else begin
      rst = r;
    end
    @(posedge clk);
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_play = 0; m_t = 0;
      e = '0;
    end else begin
      p = m_d2;
      m_d2 = m_d1;
      m_d1 = en;
      if (p) m_t = m_play ? m_t + 1 : 0;
      m_play = p;
      e.playing = p;
      e.step    = p ? 4'((m_t / SC) % 16) : 4'd0;
      e.audio   = p && (m_t >= 1) && phase_at(m_t - 1) && gate_at(m_t - 1);
    end
    last_exp_audio = e.audio;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("playing", playing, e.playing);
        check("step_idx", step_idx, e.step);
        check("audio_out", audio_out, e.audio);
      end
    end
  end

  initial begin : stimulus
    int len;
    bit en;
    int guard;
    repeat (4) tick(0, 1);
    repeat (1000) tick(0, 0);                 // idle with enable low
    repeat (16 * SC + 3000) tick(1, 0);       // full melody and wrap
    guard = 0;
    while (!last_exp_audio && guard < SC) begin
      tick(1, 0);
      guard++;
    end
    check("found_high_level", last_exp_audio, 1);
    repeat (10) tick(0, 0);                   // disable mid-tone
    repeat (3000) tick(1, 0);                 // restart from step 0
    for (int i = 0; i < 30; i++) begin
      en  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3000)
                                        : $urandom_range(1, 5);
      repeat (len) tick(en, 0);
    end
    repeat (500) tick(1, 0);
    tick(1, 1);                               // reset while playing
    repeat (2) tick(1, 1);
    repeat (300) tick(1, 0);
    repeat (5) tick(0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
